dds_sweep_controller: RTL and testbench

- Sequences the DDS frequency tuning word (FTW) through a linear frequency sweep.
- Step rate is taken from one selectable tap of the clock_divider output bus `slow_clock[9:0]`.
- Sits between the clock_divider and the DDS phase accumulator, and runs entirely in the `fast_clock` domain.
- Divider taps are sampled as data, never used as clocks.

---
 rtl/dds_pkg.sv | 21 ++
 rtl/tap_edge_detect.sv | 45 ++++
 rtl/dds_sweep_controller.sv | 178 +++++++++++++++++
 tb/tb_dds_sweep_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants and state type for the DDS sweep controller
package dds_pkg;

    localparam int DEF_FTW_W = 32;
    localparam int DEF_TAP_N = 10;
    localparam int DEF_SEL_W = 4;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_REPEAT = 2'b01;
    localparam logic [1:0] MODE_TRI    = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RUN_UP,
        RUN_DN,
        WRAP,
        DONE
    } state_t;

endpackage

// File: rtl/tap_edge_detect.sv
// rtl/tap_edge_detect.sv - selects one divider tap and flags its 0->1 transitions as data
module tap_edge_detect #(
    parameter int TAP_N = 10,
    parameter int SEL_W = 4
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic [TAP_N-1:0] taps_i,
    input  logic [SEL_W-1:0] sel_i,
    input  logic             preload_i,
    input  logic [SEL_W-1:0] preload_sel_i,
    output logic             tick_o
);

    localparam int PAD_N = 1 << SEL_W;

    logic [PAD_N-1:0] taps_ext;
    logic             tap;
    logic             tap_d_q;
    logic             tap_d_d;

    // Out-of-range selects read a constant 0 instead of indexing past the bus.
    always_comb begin
        taps_ext              = '0;
        taps_ext[TAP_N-1:0]   = taps_i;
    end

    assign tap = taps_ext[sel_i];

    // Preloading with the newly selected tap hides a level that is already high.
    always_comb begin
        tap_d_d = preload_i ? taps_ext[preload_sel_i] : tap;
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            tap_d_q <= 1'b0;
        end else begin
            tap_d_q <= tap_d_d;
        end
    end

    assign tick_o = tap & ~tap_d_q;

endmodule

// File: rtl/dds_sweep_controller.sv
// rtl/dds_sweep_controller.sv - steps the DDS tuning word through single, repeat or triangle sweeps
module dds_sweep_controller
    import dds_pkg::*;
#(
    parameter int FTW_W = DEF_FTW_W,
    parameter int TAP_N = DEF_TAP_N,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic             fast_clock,
    input  logic             rst,
    input  logic [TAP_N-1:0] slow_clock,
    input  logic [SEL_W-1:0] tap_sel,
    input  logic [1:0]       mode,
    input  logic [FTW_W-1:0] start_word,
    input  logic [FTW_W-1:0] stop_word,
    input  logic [FTW_W-1:0] step,
    input  logic             start,
    input  logic             abort,
    output logic [FTW_W-1:0] ftw,
    output logic             busy,
    output logic             step_stb,
    output logic             done,
    output logic             cfg_err
);

    state_t             state_q, state_d;
    logic [FTW_W-1:0]   ftw_q, ftw_d;
    logic               busy_q, busy_d;
    logic               stb_q, stb_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic [1:0]         mode_q, mode_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [FTW_W-1:0]   lo_q, lo_d;
    logic [FTW_W-1:0]   hi_q, hi_d;
    logic [FTW_W-1:0]   inc_q, inc_d;

    logic               preload;
    logic               tick;
    logic               cfg_bad;
    logic [31:0]        sel_ext;
    logic [FTW_W:0]     sum;
    logic [FTW_W:0]     diff;

    tap_edge_detect #(
        .TAP_N (TAP_N),
        .SEL_W (SEL_W)
    ) u_tap_edge (
        .clk_i         (fast_clock),
        .resetn_i      (rst),
        .taps_i        (slow_clock),
        .sel_i         (sel_q),
        .preload_i     (preload),
        .preload_sel_i (tap_sel),
        .tick_o        (tick)
    );

    assign sel_ext = 32'(tap_sel);
    assign cfg_bad = (step == '0) || (start_word > stop_word) ||
                     (mode == MODE_RSVD) || (sel_ext >= 32'(TAP_N));

    // One extra bit exposes carry-out on the way up and borrow on the way down.
    assign sum  = {1'b0, ftw_q} + {1'b0, inc_q};
    assign diff = {1'b0, ftw_q} - {1'b0, inc_q};

    always_comb begin
        state_d = state_q;
        ftw_d   = ftw_q;
        stb_d   = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        mode_d  = mode_q;
        sel_d   = sel_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        inc_d   = inc_q;
        preload = 1'b0;

        if (state_q != IDLE && abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (cfg_bad) begin
                            err_d = 1'b1;
                        end else begin
                            mode_d  = mode;
                            sel_d   = tap_sel;
                            lo_d    = start_word;
                            hi_d    = stop_word;
                            inc_d   = step;
                            ftw_d   = start_word;
                            stb_d   = 1'b1;
                            preload = 1'b1;
                            state_d = RUN_UP;
                        end
                    end
                end
                RUN_UP: begin
                    if (tick) begin
                        stb_d = 1'b1;
                        if (sum < {1'b0, hi_q}) begin
                            ftw_d = sum[FTW_W-1:0];
                        end else begin
                            ftw_d = hi_q;
                            case (mode_q)
                                MODE_SINGLE: state_d = DONE;
                                MODE_REPEAT: state_d = WRAP;
                                default:     state_d = RUN_DN;
                            endcase
                        end
                    end
                end
                RUN_DN: begin
                    if (tick) begin
                        stb_d = 1'b1;
                        if (diff[FTW_W] || (diff[FTW_W-1:0] <= lo_q)) begin
                            ftw_d   = lo_q;
                            state_d = RUN_UP;
                        end else begin
                            ftw_d = diff[FTW_W-1:0];
                        end
                    end
                end
                WRAP: begin
                    if (tick) begin
                        stb_d   = 1'b1;
                        ftw_d   = lo_q;
                        state_d = RUN_UP;
                    end
                end
                DONE: begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d == RUN_UP) || (state_d == RUN_DN);
    end

    always_ff @(posedge fast_clock) begin
        if (!rst) begin
            state_q <= IDLE;
            ftw_q   <= '0;
            busy_q  <= 1'b0;
            stb_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            mode_q  <= MODE_SINGLE;
            sel_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            inc_q   <= '0;
        end else begin
            state_q <= state_d;
            ftw_q   <= ftw_d;
            busy_q  <= busy_d;
            stb_q   <= stb_d;
            done_q  <= done_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            inc_q   <= inc_d;
        end
    end

    assign ftw      = ftw_q;
    assign busy     = busy_q;
    assign step_stb = stb_q;
    assign done     = done_q;
    assign cfg_err  = err_q;

endmodule

// File: tb/tb_dds_sweep_controller.sv
// tb/tb_dds_sweep_controller.sv - directed and randomized checks of dds_sweep_controller against a sweep model
module tb_dds_sweep_controller;

    logic        fast_clock;
    logic        rst;
    logic [9:0]  slow_clock;
    logic [3:0]  tap_sel;
    logic [1:0]  mode;
    logic [31:0] start_word;
    logic [31:0] stop_word;
    logic [31:0] step;
    logic        start;
    logic        abort;
    logic [31:0] ftw;
    logic        busy;
    logic        step_stb;
    logic        done;
    logic        cfg_err;

    dds_sweep_controller dut (
        .fast_clock (fast_clock),
        .rst        (rst),
        .slow_clock (slow_clock),
        .tap_sel    (tap_sel),
        .mode       (mode),
        .start_word (start_word),
        .stop_word  (stop_word),
        .step       (step),
        .start      (start),
        .abort      (abort),
        .ftw        (ftw),
        .busy       (busy),
        .step_stb   (step_stb),
        .done       (done),
        .cfg_err    (cfg_err)
    );

    initial begin
        fast_clock = 1'b0;
        forever #5 fast_clock = ~fast_clock;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int stb_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Sweep model: phases of the sweep tracked as plain integers, arithmetic done in 64 bits.
    localparam int P_IDLE = 0, P_UP = 1, P_DOWN = 2, P_HOLD = 3, P_FIN = 4;
    int          ph;
    longint      m_ftw, m_lo, m_hi, m_inc;
    int          m_sel, m_mode;
    logic        m_busy, m_stb, m_done, m_err;
    logic        model_ok = 1'b0;
    logic [9:0]  prev_bus = '0;

    always @(posedge fast_clock) begin
        logic   tk;
        longint nx;
        if (!rst) begin
            ph = P_IDLE; m_ftw = 0; m_lo = 0; m_hi = 0; m_inc = 0; m_sel = 0; m_mode = 0;
            m_busy = 0; m_stb = 0; m_done = 0; m_err = 0;
            model_ok = 1'b1;
        end else begin
            tk = slow_clock[m_sel] && !prev_bus[m_sel];
            m_stb = 0; m_done = 0; m_err = 0;
            if (ph == P_IDLE) begin
                if (start && !abort) begin
                    if (step == 0 || start_word > stop_word || mode == 2'd3 || int'(tap_sel) >= 10) begin
                        m_err = 1;
                    end else begin
                        m_lo = start_word; m_hi = stop_word; m_inc = step;
                        m_sel = int'(tap_sel); m_mode = int'(mode);
                        m_ftw = m_lo; m_stb = 1; ph = P_UP;
                    end
                end
            end else if (abort) begin
                ph = P_IDLE;
            end else if (ph == P_FIN) begin
                m_done = 1; ph = P_IDLE;
            end else if (tk) begin
                m_stb = 1;
                if (ph == P_UP) begin
                    nx = m_ftw + m_inc;
                    if (nx < m_hi) m_ftw = nx;
                    else begin
                        m_ftw = m_hi;
                        ph = (m_mode == 0) ? P_FIN : (m_mode == 1) ? P_HOLD : P_DOWN;
                    end
                end else if (ph == P_DOWN) begin
                    nx = m_ftw - m_inc;
                    if (nx <= m_lo) begin m_ftw = m_lo; ph = P_UP; end
                    else m_ftw = nx;
                end else begin
                    m_ftw = m_lo; ph = P_UP;
                end
            end
            m_busy = (ph == P_UP) || (ph == P_DOWN);
        end
        prev_bus = slow_clock;
    end

    always @(negedge fast_clock) begin
        if (model_ok) begin
            chk("ftw", ftw, m_ftw[31:0]);
            chk("busy", busy, m_busy);
            chk("step_stb", step_stb, m_stb);
            chk("done", done, m_done);
            chk("cfg_err", cfg_err, m_err);
        end
        if (done === 1'b1) done_cnt++;
        if (step_stb === 1'b1) stb_cnt++;
    end

    task automatic clk1();
        @(posedge fast_clock);
        #1;
    endtask

    task automatic do_start(input int sel, input int md, input logic [31:0] sw,
                            input logic [31:0] pw, input logic [31:0] st);
        tap_sel = 4'(sel); mode = 2'(md); start_word = sw; stop_word = pw; step = st;
        start = 1'b1;
        clk1();
        start = 1'b0;
    endtask

    task automatic pulse_tap(input int b, output logic [31:0] f, output logic s);
        slow_clock[b] = 1'b1;
        clk1();
        f = ftw; s = step_stb;
        slow_clock[b] = 1'b0;
        clk1();
        clk1();
    endtask

    logic [31:0] f;
    logic        s;
    int          d0, s0;
    int          rep_exp[5] = '{8, 16, 20, 0, 8};
    int          tri_exp[7] = '{8, 16, 20, 12, 4, 0, 8};

    initial begin
        rst = 1'b0; slow_clock = '0; tap_sel = '0; mode = '0;
        start_word = '0; stop_word = '0; step = '0; start = 1'b0; abort = 1'b0;
        repeat (3) clk1();
        rst = 1'b1;
        clk1();
        chk("reset_ftw", ftw, 0);
        chk("reset_busy", busy, 0);

        // Single sweep 100..130 step 10 on tap 3.
        do_start(3, 0, 100, 130, 10);
        chk("single_first_ftw", ftw, 100);
        chk("single_first_stb", step_stb, 1);
        chk("single_busy", busy, 1);
        d0 = done_cnt;
        for (int i = 1; i <= 3; i++) begin
            pulse_tap(3, f, s);
            chk("single_ftw", f, 64'(100 + 10 * i));
            chk("single_stb", s, 1);
        end
        chk("single_done_once", done_cnt - d0, 1);
        chk("single_idle_busy", busy, 0);
        pulse_tap(3, f, s);
        chk("single_extra_tick_stb", s, 0);
        chk("single_hold_ftw", f, 130);

        // Saturation past the top of the word.
        do_start(5, 0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20);
        d0 = done_cnt;
        pulse_tap(5, f, s);
        chk("sat_ftw", f, 64'hFFFF_FFFF);
        chk("sat_done", done_cnt - d0, 1);

        // Repeat sweep.
        do_start(1, 1, 0, 20, 8);
        chk("rep_first", ftw, 0);
        for (int i = 0; i < 5; i++) begin
            pulse_tap(1, f, s);
            chk("rep_seq", f, 64'(rep_exp[i]));
        end
        abort = 1'b1; clk1(); abort = 1'b0;

        // Triangle sweep.
        do_start(1, 2, 0, 20, 8);
        chk("tri_first", ftw, 0);
        for (int i = 0; i < 7; i++) begin
            pulse_tap(1, f, s);
            chk("tri_seq", f, 64'(tri_exp[i]));
        end
        abort = 1'b1; clk1(); abort = 1'b0;
        chk("tri_abort_busy", busy, 0);
        chk("tri_abort_ftw", ftw, 8);

        // Rejected starts leave ftw and busy alone.
        do_start(1, 0, 0, 20, 0);
        chk("err_step0", cfg_err, 1); chk("err_step0_ftw", ftw, 8); chk("err_step0_busy", busy, 0);
        do_start(1, 0, 50, 10, 5);
        chk("err_order", cfg_err, 1); chk("err_order_ftw", ftw, 8);
        do_start(1, 3, 0, 20, 5);
        chk("err_mode", cfg_err, 1); chk("err_mode_busy", busy, 0);
        do_start(12, 0, 0, 20, 5);
        chk("err_sel", cfg_err, 1); chk("err_sel_ftw", ftw, 8);
        abort = 1'b1;
        do_start(1, 0, 0, 20, 5);
        abort = 1'b0;
        chk("start_abort_err", cfg_err, 0); chk("start_abort_busy", busy, 0);

        // Abort colliding with a tick, then start with the tap already high.
        do_start(2, 0, 0, 100, 10);
        for (int i = 0; i < 4; i++) pulse_tap(2, f, s);
        chk("abort_pre_ftw", ftw, 40);
        slow_clock[2] = 1'b1; abort = 1'b1;
        clk1();
        chk("abort_ftw", ftw, 40); chk("abort_stb", step_stb, 0); chk("abort_busy", busy, 0);
        abort = 1'b0; slow_clock[2] = 1'b0;
        clk1();
        slow_clock[4] = 1'b1;
        clk1();
        s0 = stb_cnt;
        do_start(4, 0, 0, 100, 10);
        repeat (3) clk1();
        chk("high_tap_no_tick", stb_cnt - s0, 1);
        slow_clock[4] = 1'b0;
        clk1();
        pulse_tap(4, f, s);
        chk("high_tap_next_edge", f, 10); chk("high_tap_next_stb", s, 1);

        // Reset mid RUN_UP.
        d0 = done_cnt;
        rst = 1'b0;
        repeat (3) clk1();
        rst = 1'b1;
        chk("midreset_ftw", ftw, 0); chk("midreset_busy", busy, 0);
        s0 = stb_cnt;
        pulse_tap(4, f, s);
        chk("midreset_no_stb", stb_cnt - s0, 0);
        chk("midreset_no_done", done_cnt - d0, 0);

        // Randomized traffic checked by the model every cycle.
        for (int c = 0; c < 6000; c++) begin
            for (int b = 0; b < 10; b++)
                if ($urandom_range(0, 3) == 0) slow_clock[b] = ~slow_clock[b];
            start = ($urandom_range(0, 15) == 0);
            if (start) begin
                tap_sel = 4'($urandom_range(0, 11));
                mode    = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 5))
                    0:       step = 0;
                    1:       step = $urandom;
                    default: step = $urandom_range(1, 40);
                endcase
                if ($urandom_range(0, 3) == 0) start_word = 32'hFFFF_FF00 + $urandom_range(0, 255);
                else start_word = $urandom_range(0, 200);
                stop_word = start_word + $urandom_range(0, 150);
                if ($urandom_range(0, 9) == 0) stop_word = $urandom_range(0, 100);
            end
            abort = ($urandom_range(0, 63) == 0);
            rst   = ($urandom_range(0, 511) != 0);
            clk1();
        end
        start = 1'b0; abort = 1'b0; rst = 1'b1;
        repeat (3) clk1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
